// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - multi-cycle word/halfword/byte store path with read-modify-write merge
//
// Purpose:
//   Writes the register file's B operand to word-addressed data memory.
//   Word stores are written directly. Halfword and byte stores read the
//   existing word, merge the selected little-endian lanes, and write the
//   result back.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   request pulse, sampled only in IDLE
//   store_size   in   00 word, 01 halfword, 10 byte, 11 word
//   addr         in   byte address of the store
//   reg_b        in   store data (low byte/halfword for sub-word stores)
//   mem_rdata    in   memory read data, valid the cycle after mem_rd
//   mem_addr     out  word-aligned address of the latched request
//   mem_wdata    out  word to write
//   mem_rd       out  memory read strobe
//   mem_wr       out  memory write strobe
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//   misaligned   out  trap flag, high together with done
//
// Configuration:
//   STORE_MISALIGN_TRAP_EN  defined: misaligned halfword/word requests skip
//                           memory and finish with misaligned=1.
//                           undefined: low address bits are ignored and
//                           misaligned is tied to 0.

module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_size,
    input  logic [31:0] addr,
    input  logic [31:0] reg_b,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    // Holds the store data at request time; for sub-word stores it is
    // overwritten with the merged word in CAPTURE, so it is always the
    // word to write by the time WRITE is reached.
    logic [31:0] reg_b_q;
    logic [31:0] merged;

    logic        req_half;
    logic        req_byte;
    logic        req_word;
    logic        req_trap;

    assign req_half = (store_size == 2'b01);
    assign req_byte = (store_size == 2'b10);
    assign req_word = !req_half && !req_byte;

`ifdef STORE_MISALIGN_TRAP_EN
    logic trap_q;
    assign req_trap   = (req_half && addr[0]) || (req_word && (addr[1:0] != 2'b00));
    assign misaligned = (state == S_DONE) && trap_q;
`else
    assign req_trap   = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Strobes are pure state decodes so an asynchronous reset drops them
    // in the same instant it clears the state register.
    assign mem_rd    = (state == S_READ);
    assign mem_wr    = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = reg_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (req_trap) begin
                        state_n = S_DONE;
                    end else if (req_word) begin
                        state_n = S_WRITE;
                    end else begin
                        state_n = S_READ;
                    end
                end
            end
            S_READ:    state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_WRITE;
            S_WRITE:   state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Little-endian lane merge: lane 0 is bits 7:0.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b10) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = reg_b_q[7:0];
                2'd1: merged[15:8]  = reg_b_q[7:0];
                2'd2: merged[23:16] = reg_b_q[7:0];
                default: merged[31:24] = reg_b_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = reg_b_q[15:0];
        end else begin
            merged[15:0] = reg_b_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            reg_b_q <= 32'd0;
`ifdef STORE_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= addr;
                        size_q  <= store_size;
                        reg_b_q <= reg_b;
`ifdef STORE_MISALIGN_TRAP_EN
                        trap_q  <= req_trap;
`endif
                    end
                end
                S_CAPTURE: begin
                    reg_b_q <= merged;
                end
                S_DONE: begin
`ifdef STORE_MISALIGN_TRAP_EN
                    trap_q <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - self-checking bench for store_merge_unit

module tb_store_merge_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] reg_b;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        misaligned;

    int passed;
    int total;
    int wr_cnt;
    int rd_cnt;
    int done_cnt;

    // Expected writes: {word address, write data}
    logic [63:0] exp_q[$];

    store_merge_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .store_size (store_size),
        .addr       (addr),
        .reg_b      (reg_b),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every write strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        $display("FAIL scoreboard_write: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wdata, e[63:32], e[31:0]);
                    end else begin
                        passed++;
                    end
                end
            end
            if (mem_rd) rd_cnt++;
            if (done) done_cnt++;
            if (mem_rd && mem_wr) begin
                total++;
                $display("FAIL rd_wr_overlap: got rd=1 wr=1, required never both");
            end
        end
    end

    function automatic logic [31:0] model(input logic [1:0] sz, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] rd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            return (rd & ~mask) | ((b & 32'h0000_00FF) << sh);
        end else if (sz == 2'b01) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (rd & ~mask) | ((b & 32'h0000_FFFF) << sh);
        end
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one store, scrambles the request inputs after the sampling
    // edge, and checks strobe timing cycle by cycle.
    task automatic run_store(input string name, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] rd,
                             input logic [31:0] exp, input bit sub);
        exp_q.push_back({a[31:2], 2'b00, exp});
        tick();
        start = 1'b1; store_size = sz; addr = a; reg_b = b; mem_rdata = rd;
        tick();
        start = 1'b0; addr = $urandom; reg_b = $urandom; store_size = 2'b10;
        if (sub) begin
            total++;
            if ({mem_rd, mem_wr, mem_addr} !== {2'b10, a[31:2], 2'b00}) begin
                $display("FAIL %s_read: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=%h",
                         name, mem_rd, mem_wr, mem_addr, {a[31:2], 2'b00});
            end else passed++;
            tick();
            total++;
            if ({busy, mem_rd, mem_wr, done} !== 4'b1000) begin
                $display("FAIL %s_capture: got busy/rd/wr/done=%b, required 1000", name, {busy, mem_rd, mem_wr, done});
            end else passed++;
            tick();
        end
        total++;
        if ({mem_wr, mem_rd, mem_wdata} !== {2'b10, exp}) begin
            $display("FAIL %s_write: got wr=%b rd=%b wdata=%h, required wr=1 rd=0 wdata=%h",
                     name, mem_wr, mem_rd, mem_wdata, exp);
        end else passed++;
        tick();
        total++;
        if ({done, misaligned, mem_wr} !== 3'b100) begin
            $display("FAIL %s_done: got done=%b misaligned=%b wr=%b, required 1 0 0", name, done, misaligned, mem_wr);
        end else passed++;
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL %s_idle: got busy=%b done=%b, required 0 0", name, busy, done);
        end else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; store_size = 2'b00; addr = 32'd0; reg_b = 32'd0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_rd, mem_wr, busy, done, misaligned, mem_addr, mem_wdata} !== 69'd0) begin
            $display("FAIL reset_outputs: got rd=%b wr=%b busy=%b done=%b mis=%b addr=%h wdata=%h, required all 0",
                     mem_rd, mem_wr, busy, done, misaligned, mem_addr, mem_wdata);
        end else passed++;
        reset = 1'b0;
    endtask

    task automatic test_word;
        int rd0;
        rd0 = rd_cnt;
        run_store("word", 2'b00, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        total++;
        if (rd_cnt !== rd0) begin
            $display("FAIL word_no_read: got %0d reads, required 0", rd_cnt - rd0);
        end else passed++;
        run_store("word_sz3", 2'b11, 32'h0000_2008, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_byte;
        run_store("byte_lane3", 2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 1'b1);
        run_store("byte_lane0", 2'b10, 32'h0000_1000, 32'h0000_00AB, 32'h1122_3344, 32'h1122_33AB, 1'b1);
    endtask

    task automatic test_half;
        run_store("half_hi", 2'b01, 32'h0000_1002, 32'h1234_BEEF, 32'h1122_3344, 32'hBEEF_3344, 1'b1);
    endtask

    task automatic test_misaligned;
`ifdef STORE_MISALIGN_TRAP_EN
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        tick();
        start = 1'b1; store_size = 2'b01; addr = 32'h0000_1001; reg_b = 32'h0000_CAFE; mem_rdata = 32'h1122_3344;
        tick();
        start = 1'b0;
        total++;
        if ({done, misaligned, mem_rd, mem_wr} !== 4'b1100) begin
            $display("FAIL misaligned_trap: got done/mis/rd/wr=%b, required 1100", {done, misaligned, mem_rd, mem_wr});
        end else passed++;
        tick();
        total++;
        if ({busy, misaligned} !== 2'b00) begin
            $display("FAIL misaligned_clear: got busy=%b mis=%b, required 0 0", busy, misaligned);
        end else passed++;
        total++;
        if ((rd_cnt - rd0) + (wr_cnt - wr0) !== 0) begin
            $display("FAIL misaligned_no_access: got %0d accesses, required 0", (rd_cnt - rd0) + (wr_cnt - wr0));
        end else passed++;
`else
        run_store("half_odd", 2'b01, 32'h0000_1001, 32'h0000_CAFE, 32'h1122_3344, 32'h1122_CAFE, 1'b1);
`endif
    endtask

    task automatic test_start_while_busy;
        int d0, w0;
        d0 = done_cnt; w0 = wr_cnt;
        exp_q.push_back({32'h0000_3000, 32'hAABB_55DD});
        tick();
        start = 1'b1; store_size = 2'b10; addr = 32'h0000_3001; reg_b = 32'h0000_0055; mem_rdata = 32'hAABB_CCDD;
        tick();
        start = 1'b0;                         // READ
        tick();                               // CAPTURE
        start = 1'b1; store_size = 2'b00; addr = 32'h0000_4000; reg_b = 32'hFFFF_FFFF;
        tick();                               // WRITE
        start = 1'b0;
        total++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_3000, 32'hAABB_55DD}) begin
            $display("FAIL busy_start_write: got wr=%b addr=%h wdata=%h, required 1 00003000 aabb55dd",
                     mem_wr, mem_addr, mem_wdata);
        end else passed++;
        repeat (6) tick();
        total++;
        if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1) begin
            $display("FAIL busy_start_single: got done=%0d writes=%0d, required 1 1", done_cnt - d0, wr_cnt - w0);
        end else passed++;
    endtask

    task automatic test_reset_mid;
        int w0;
        w0 = wr_cnt;
        exp_q.push_back({32'h0000_5000, 32'h0000_0000});
        tick();
        start = 1'b1; store_size = 2'b10; addr = 32'h0000_5002; reg_b = 32'h0000_0077; mem_rdata = 32'h0;
        tick();
        start = 1'b0;                         // READ
        tick();                               // CAPTURE
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, mem_wr, mem_rd, done} !== 4'b0000) begin
            $display("FAIL reset_mid_async: got busy/wr/rd/done=%b, required 0000", {busy, mem_wr, mem_rd, done});
        end else passed++;
        exp_q.delete();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        total++;
        if (wr_cnt !== w0 || busy !== 1'b0) begin
            $display("FAIL reset_mid_no_write: got writes=%0d busy=%b, required 0 0", wr_cnt - w0, busy);
        end else passed++;
        run_store("post_reset_word", 2'b00, 32'h0000_6000, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  sz;
            logic [31:0] a, b, rd;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom; b = $urandom; rd = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b00 || sz == 2'b11) a[1:0] = 2'b00;
            run_store("random", sz, a, b, rd, model(sz, a, b, rd), (sz == 2'b01 || sz == 2'b10));
        end
    endtask

    initial begin
        passed = 0; total = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Multi-cycle store path between the register file's B operand and the word-addressed data memory. The writeback mux returns loaded data to the register file; this block handles the opposite direction. It takes a store request (word, halfword or byte) and writes it to memory. Word stores are written directly. Sub-word stores use a read-modify-write sequence that merges the selected lanes of `reg_b` into the existing memory word. It sits beside the load path and is started by the control FSM during the store state.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `store_size`  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
- `addr`  in  32  byte address of the store
- `reg_b`  in  32  store data; low byte or halfword is used for sub-word stores
- `mem_rdata`  in  32  memory read data; valid the cycle after `mem_rd`
- `mem_addr`  out  32  word-aligned address, `{addr_q[31:2],2'b00}`
- `mem_wdata`  out  32  word to write
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  misalignment flag; meaning depends on Configuration

## Operation

- On `start` in IDLE, latch `addr`, `store_size` and `reg_b` into internal registers. Inputs are not used afterwards.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE:
  - Word request goes to WRITE.
  - Sub-word request goes to READ.
  - Misaligned request is handled as described under Configuration.
- READ: `mem_rd`=1 and `mem_addr` driven; go to CAPTURE.
- CAPTURE: register `mem_rdata` merged with the store data; go to WRITE.
  - Byte: lane `addr_q[1:0]` (0 = bits 7:0 … 3 = bits 31:24) is replaced by `reg_b_q[7:0]`.
  - Half: `addr_q[1]`=0 replaces bits 15:0, `addr_q[1]`=1 replaces bits 31:16, with `reg_b_q[15:0]`.
- WRITE: `mem_wr`=1 for exactly one cycle; `mem_wdata` is `reg_b_q` (word) or the merged word; go to DONE.
- DONE: `done`=1; go to IDLE.
- `start` while busy is ignored, with no queuing.
- Little-endian lane ordering.

## Timing

- Reset values:
  - State IDLE.
  - `mem_rd`, `mem_wr`, `busy`, `done`, `misaligned` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - All internal registers are 0.
- All outputs are registered or decoded from state only. No combinational path from `start` to any output.
- Word store, `start` sampled at edge T:
  - WRITE during cycle T+1.
  - `done` during T+2.
  - Back in IDLE at T+3.
- Sub-word store, `start` sampled at edge T:
  - READ during T+1.
  - CAPTURE during T+2, with `mem_rdata` sampled at the end of T+2.
  - WRITE during T+3.
  - `done` during T+4.
- `mem_addr` is stable from READ or WRITE entry through DONE.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- A new `start` is accepted no earlier than the cycle after `done`.
- Reset asserted mid-operation:
  - Immediately returns the block to IDLE and drops `mem_wr`/`mem_rd`, asynchronously.
  - No partial write is completed.

## Configuration

Macro `STORE_MISALIGN_TRAP_EN`.

- **Defined.** Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - A misaligned request goes IDLE → DONE. No memory access is made.
  - `misaligned`=1 together with `done` (same cycle only).
- **Undefined.**
  - `addr[0]` is ignored for halfwords, and `addr[1:0]` is ignored for words.
  - The store proceeds on the aligned address.
  - `misaligned` is tied to 0.

## Test plan

- Word store: `addr`=0x0000_1004, `reg_b`=0xDEADBEEF, size 00.
  - Expect `mem_wr` at T+1 with `mem_addr`=0x1004 and `mem_wdata`=0xDEADBEEF.
  - Expect `done` at T+2.
  - Expect no `mem_rd`.
- Byte store: `addr`=0x1003, `reg_b`=0x000000AB, `mem_rdata`=0x11223344.
  - Expect `mem_rd` at T+1 and `mem_wr` at T+3 with `mem_wdata`=0xAB223344.
  - Repeat with `addr`=0x1000: expect 0x112233AB.
- Halfword store: `addr`=0x1002, `reg_b`=0x1234BEEF, `mem_rdata`=0x11223344.
  - Expect `mem_wdata`=0xBEEF3344 and `done` at T+4.
- Misaligned halfword: `addr`=0x1001.
  - With the macro: `done`=1 and `misaligned`=1 at T+1, no `mem_rd` or `mem_wr`.
  - Without the macro: written at lanes 15:0, `misaligned`=0.
- `start` pulsed again during CAPTURE with different data.
  - Expect it ignored: the original store completes unchanged and exactly one `done` pulse occurs.
- `reset` asserted during CAPTURE of a byte store.
  - Expect `busy`=0 immediately and no `mem_wr` afterwards.
  - Expect a subsequent word store to complete normally.
